// File: rtl/vec_result_drain.sv
// Double-buffered drain of a 16-lane vector ALU result into a one-lane-per-beat
// valid/ready stream; captures arriving while both buffers are full are counted and dropped.
`timescale 1ns/1ps
module vec_result_drain #(
  parameter int W      = 32,
  parameter int NLANES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vec_alu_op,
  input  logic [NLANES*W-1:0]   res_in,
  input  logic [29:0]           instr_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [3:0]            out_idx,
  output logic                  out_last,
  output logic [29:0]           out_tag,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int CW = $clog2(NLANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(NLANES - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_full_q, pend_full_d;
  logic [7:0]           drop_q, drop_d;
  logic [NLANES*W-1:0]  act_data_q, pend_data_q;
  logic [29:0]          act_tag_q, pend_tag_q;

  logic act_load, act_from_pend, pend_load;
  logic handshake, at_last;

  assign handshake = (state_q == S_STREAM) && out_ready;
  assign at_last   = (cnt_q == LAST_LANE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      drop_q      <= drop_d;
    end
  end

  // NOTE: payload buffers carry no reset; their contents are only visible
  // through outputs gated by the reset-cleared state and full flags.
  always_ff @(posedge clk) begin
    if (act_load) begin
      act_data_q <= act_from_pend ? pend_data_q : res_in;
      act_tag_q  <= act_from_pend ? pend_tag_q  : instr_tag;
    end
    if (pend_load) begin
      pend_data_q <= res_in;
      pend_tag_q  <= instr_tag;
    end
  end

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_full_d   = pend_full_q;
    drop_d        = drop_q;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vec_alu_op) begin
          act_load = 1'b1;
          cnt_d    = '0;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (handshake && at_last) begin
          cnt_d = '0;
          // Active buffer frees this edge: refill from pending or straight from the capture.
          if (pend_full_q) begin
            act_load      = 1'b1;
            act_from_pend = 1'b1;
            if (vec_alu_op) pend_load   = 1'b1;
            else            pend_full_d = 1'b0;
          end else if (vec_alu_op) begin
            act_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (handshake) cnt_d = cnt_q + CW'(1);
          if (vec_alu_op) begin
            if (!pend_full_q) begin
              pend_load   = 1'b1;
              pend_full_d = 1'b1;
            end else if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_STREAM);
    busy      = out_valid || pend_full_q;
    drop_cnt  = drop_q;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_tag   = '0;
    if (out_valid) begin
      out_data = act_data_q[cnt_q*W +: W];
      out_idx  = 4'(cnt_q);
      out_last = at_last;
      out_tag  = act_tag_q;
    end
  end

endmodule

// File: tb/tb_vec_result_drain.sv
// Directed bench for vec_result_drain: drain, backpressure, back-to-back,
// overflow/saturation, simultaneous capture at the last lane, mid-stream reset.
`timescale 1ns/1ps
module tb_vec_result_drain;

  localparam int W      = 32;
  localparam int NLANES = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                vec_alu_op;
  logic [NLANES*W-1:0] res_in;
  logic [29:0]         instr_tag;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [3:0]          out_idx;
  logic                out_last;
  logic [29:0]         out_tag;
  logic                busy;
  logic [7:0]          drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vec_result_drain #(.W(W), .NLANES(NLANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .vec_alu_op(vec_alu_op),
    .res_in    (res_in),
    .instr_tag (instr_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_tag   (out_tag),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic [W-1:0] base, input logic [29:0] tag);
    for (int k = 0; k < NLANES; k++) res_in[k*W +: W] = base + W'(k);
    instr_tag = tag;
  endtask

  task automatic capture(input logic [W-1:0] base, input logic [29:0] tag);
    vec_alu_op = 1'b1;
    set_res(base, tag);
    cyc();
    vec_alu_op = 1'b0;
  endtask

  task automatic check_lane(input string nm, input logic [W-1:0] base,
                            input logic [29:0] tag, input int k);
    check($sformatf("%s_valid[%0d]", nm, k), 64'(out_valid), 64'(1));
    check($sformatf("%s_idx[%0d]",   nm, k), 64'(out_idx),   64'(k));
    check($sformatf("%s_data[%0d]",  nm, k), 64'(out_data),  64'(base + W'(k)));
    check($sformatf("%s_last[%0d]",  nm, k), 64'(out_last),  64'(k == NLANES-1));
    check($sformatf("%s_tag[%0d]",   nm, k), 64'(out_tag),   64'(tag));
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_valid"}, 64'(out_valid), 64'(0));
    check({nm, "_busy"},  64'(busy),      64'(0));
    check({nm, "_data"},  64'(out_data),  64'(0));
    check({nm, "_idx"},   64'(out_idx),   64'(0));
    check({nm, "_last"},  64'(out_last),  64'(0));
    check({nm, "_tag"},   64'(out_tag),   64'(0));
  endtask

  // Drain one capture with out_ready high; up to two captures injected at chosen lanes.
  task automatic drain(input string nm, input logic [W-1:0] base, input logic [29:0] tag,
                       input int a_k = -1, input logic [W-1:0] a_base = '0, input logic [29:0] a_tag = '0,
                       input int b_k = -1, input logic [W-1:0] b_base = '0, input logic [29:0] b_tag = '0);
    out_ready = 1'b1;
    for (int k = 0; k < NLANES; k++) begin
      check_lane(nm, base, tag, k);
      if (k == a_k) begin vec_alu_op = 1'b1; set_res(a_base, a_tag); end
      if (k == b_k) begin vec_alu_op = 1'b1; set_res(b_base, b_tag); end
      cyc();
      vec_alu_op = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; vec_alu_op = 1'b0; out_ready = 1'b0; res_in = '0; instr_tag = '0;
    #12;
    check_idle("reset");
    check("reset_drop", 64'(drop_cnt), 64'(0));
    @(negedge clk) rst = 1'b1;

    // Basic drain with out_ready tied high.
    out_ready = 1'b1;
    capture(32'h100, 30'h0ABCDEF);
    drain("basic", 32'h100, 30'h0ABCDEF);
    check_idle("basic_end");

    // Backpressure for 5 cycles at lane 3.
    capture(32'h300, 30'h3);
    for (int k = 0; k < 3; k++) begin check_lane("bp_pre", 32'h300, 30'h3, k); cyc(); end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin check_lane("bp_hold", 32'h300, 30'h3, 3); cyc(); end
    out_ready = 1'b1;
    for (int k = 3; k < NLANES; k++) begin check_lane("bp_post", 32'h300, 30'h3, k); cyc(); end
    check_idle("bp_end");

    // Back-to-back: second capture arrives at lane 4 of the first.
    capture(32'h100, 30'h2);
    drain("b2b_1", 32'h100, 30'h2, 4, 32'h200, 30'h1);
    drain("b2b_2", 32'h200, 30'h1);
    check_idle("b2b_end");

    // Overflow with the consumer stalled, then saturation of the drop counter.
    out_ready = 1'b0;
    capture(32'h400, 30'h4);
    capture(32'h500, 30'h5);
    check("ovf_drop0", 64'(drop_cnt), 64'(0));
    capture(32'h600, 30'h6);
    check("ovf_drop1", 64'(drop_cnt), 64'(1));
    check("ovf_busy",  64'(busy),     64'(1));
    check_lane("ovf_hold", 32'h400, 30'h4, 0);
    vec_alu_op = 1'b1;
    repeat (300) cyc();
    vec_alu_op = 1'b0;
    check("ovf_sat", 64'(drop_cnt), 64'(255));
    drain("ovf_a", 32'h400, 30'h4);
    drain("ovf_b", 32'h500, 30'h5);
    check_idle("ovf_end");
    check("ovf_sat_kept", 64'(drop_cnt), 64'(255));
    #2 rst = 1'b0;
    #1 check("ovf_rst_drop", 64'(drop_cnt), 64'(0));
    @(negedge clk) rst = 1'b1;

    // Capture coinciding with the last-lane handshake, pending empty.
    capture(32'h700, 30'h7);
    drain("sim_e", 32'h700, 30'h7, 15, 32'h800, 30'h8);
    drain("sim_e2", 32'h800, 30'h8);
    check_idle("sim_e_end");

    // Capture coinciding with the last-lane handshake, pending full.
    capture(32'h900, 30'h9);
    drain("sim_f", 32'h900, 30'h9, 2, 32'hA00, 30'hA, 15, 32'hB00, 30'hB);
    check("sim_f_nodrop", 64'(drop_cnt), 64'(0));
    drain("sim_f2", 32'hA00, 30'hA);
    drain("sim_f3", 32'hB00, 30'hB);
    check_idle("sim_f_end");
    check("sim_f_drop", 64'(drop_cnt), 64'(0));

    // Asynchronous reset at lane 7 with both buffers full and one drop counted.
    capture(32'hC00, 30'hC);
    for (int k = 0; k < 7; k++) begin
      check_lane("mrst", 32'hC00, 30'hC, k);
      if (k == 1) begin vec_alu_op = 1'b1; set_res(32'hE00, 30'hE); end
      if (k == 2) begin vec_alu_op = 1'b1; set_res(32'hF00, 30'hF); end
      cyc();
      vec_alu_op = 1'b0;
    end
    check_lane("mrst", 32'hC00, 30'hC, 7);
    check("mrst_drop_pre", 64'(drop_cnt), 64'(1));
    #2 rst = 1'b0;
    #1;
    check_idle("mrst_async");
    check("mrst_drop", 64'(drop_cnt), 64'(0));
    @(negedge clk) rst = 1'b1;
    capture(32'hD00, 30'hD);
    drain("post_rst", 32'hD00, 30'hD);
    check_idle("post_rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
